// File: rtl/line_pixel_writer.sv
// Clips drawer pixels, converts them to linear framebuffer writes and buffers them in a show-ahead FIFO; first write 1 cycle after accept.
// oe falls only when the FIFO is full (registered, no bypass); fb_ready stalls hold fb_addr/fb_data; line_done drains then pulses flush_done.
module line_pixel_writer #(
    parameter int COORD_WIDTH = 16,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 180,
    parameter int COLOR_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          pix_valid,
    input  logic signed [COORD_WIDTH-1:0] pix_x,
    input  logic signed [COORD_WIDTH-1:0] pix_y,
    input  logic        [COLOR_WIDTH-1:0] pix_color,
    input  logic                          line_done,
    input  logic                          clear_stats,
    output logic                          oe,
    output logic                          fb_we,
    input  logic                          fb_ready,
    output logic        [ADDR_WIDTH-1:0]  fb_addr,
    output logic        [COLOR_WIDTH-1:0] fb_data,
    output logic                          busy,
    output logic                          flush_done,
    output logic        [CNT_WIDTH-1:0]   pix_written,
    output logic        [CNT_WIDTH-1:0]   pix_clipped
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic signed [COORD_WIDTH-1:0] ZERO_C = '0;
    localparam logic signed [COORD_WIDTH-1:0] FBW_C  = COORD_WIDTH'(FB_WIDTH);
    localparam logic signed [COORD_WIDTH-1:0] FBH_C  = COORD_WIDTH'(FB_HEIGHT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_mem_addr [FIFO_DEPTH];
    logic [COLOR_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [PTR_W:0]         r_count;
    logic [CNT_WIDTH-1:0]   r_written;
    logic [CNT_WIDTH-1:0]   r_clipped;

    logic                   w_in_bounds;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic [ADDR_WIDTH-1:0]  w_addr;

    assign w_fifo_empty = (r_count == '0);
    assign oe           = (r_count != FULL_CNT);
    assign fb_we        = !w_fifo_empty;
    assign fb_addr      = r_mem_addr[r_rptr];
    assign fb_data      = r_mem_data[r_rptr];
    assign pix_written  = r_written;
    assign pix_clipped  = r_clipped;

    assign w_in_bounds = (pix_x >= ZERO_C) && (pix_x < FBW_C) &&
                         (pix_y >= ZERO_C) && (pix_y < FBH_C);
    assign w_accept    = pix_valid && oe;
    assign w_push      = w_accept && w_in_bounds;
    assign w_pop       = fb_we && fb_ready;
    // Only meaningful when in bounds, so the coordinates are non-negative here.
    assign w_addr      = ADDR_WIDTH'($unsigned(pix_y)) * ADDR_WIDTH'(FB_WIDTH)
                       + ADDR_WIDTH'($unsigned(pix_x));

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= w_addr;
            r_mem_data[r_wptr] <= pix_color;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_written <= '0;
            r_clipped <= '0;
        end else if (clear_stats) begin
            r_written <= '0;
            r_clipped <= '0;
        end else begin
            if (w_pop && r_written != CNT_MAX)
                r_written <= r_written + 1'b1;
            if (w_accept && !w_in_bounds && r_clipped != CNT_MAX)
                r_clipped <= r_clipped + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (line_done)      w_state_nxt = S_DRAIN;
                else if (pix_valid) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (line_done) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_fifo_empty && !w_push) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // busy drops in the same cycle flush_done fires.
    always_comb begin
        busy       = 1'b0;
        flush_done = 1'b0;
        case (r_state)
            S_ACTIVE: busy = 1'b1;
            S_DRAIN: begin
                flush_done = w_fifo_empty && !w_push;
                busy       = !flush_done;
            end
            default: begin
                busy       = 1'b0;
                flush_done = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/line_pixel_writer.md
Name: line_pixel_writer

Overview:
- Consumer end of the line-drawer pixel stream. It accepts (x, y) coordinates plus colour while the drawer's drawing strobe is high and drives the drawer's oe input as backpressure.
- Each accepted pixel is clipped to the framebuffer, converted to a linear address and buffered in a small FIFO. Buffered pixels are issued as framebuffer write requests with a valid/ready handshake.
- On the drawer's done pulse the block drains its FIFO, then pulses flush_done.
- Sits between the line rasteriser and the framebuffer BRAM write arbiter.

Parameters:
COORD_WIDTH, 16, signed coordinate width (matches the drawer)
FB_WIDTH, 320, framebuffer width in pixels
FB_HEIGHT, 180, framebuffer height in pixels
COLOR_WIDTH, 8, pixel data width
FIFO_DEPTH, 4, pixel buffer entries (power of two, >= 2)
ADDR_WIDTH, $clog2(FB_WIDTH*FB_HEIGHT), framebuffer address width
CNT_WIDTH, 16, statistics counter width

Ports:
clk_in  input  1  clock
rst_in  input  1  reset; asynchronous, active-low (asserted at 0)
pix_valid  input  1  pixel present this cycle (from drawer's drawing)
pix_x  input  COORD_WIDTH  signed x coordinate
pix_y  input  COORD_WIDTH  signed y coordinate
pix_color  input  COLOR_WIDTH  colour sampled with the pixel
line_done  input  1  one-cycle pulse from drawer: line finished
clear_stats  input  1  synchronous clear of the statistics counters
oe  output  1  pixel-accept enable to drawer (ready)
fb_we  output  1  write request valid
fb_ready  input  1  arbiter accepts the write this cycle
fb_addr  output  ADDR_WIDTH  linear address y*FB_WIDTH + x
fb_data  output  COLOR_WIDTH  pixel colour
busy  output  1  high from first activity until flush completes
flush_done  output  1  one-cycle pulse: line fully written
pix_written  output  CNT_WIDTH  framebuffer write handshakes completed, saturating
pix_clipped  output  CNT_WIDTH  accepted pixels dropped by clipping, saturating

Behaviour:
- Reset (rst_in=0, asynchronous): FIFO empty, state IDLE, fb_we=0, busy=0, flush_done=0, both counters 0. oe=1 because the FIFO is empty.
- oe = !fifo_full, decoded from registered count only; no combinational path from pix_valid or fb_ready to oe.
- Pixel accept: pix_valid && oe in cycle N. Full FIFO blocks acceptance even if a pop occurs the same cycle (no bypass).
- Clipping: an accepted pixel is kept only if 0 <= x < FB_WIDTH and 0 <= y < FB_HEIGHT, compared as signed values.
  - Kept: push {y*FB_WIDTH + x truncated to ADDR_WIDTH, pix_color} at edge N.
  - Clipped: not pushed; pix_clipped increments.
  - Clipping never deasserts oe.
- Output side: fb_we = !fifo_empty, with fb_addr/fb_data taken from the FIFO head (show-ahead).
  - Latency: a pixel accepted into an empty FIFO at cycle N has fb_we=1 at cycle N+1.
  - A write completes on fb_we && fb_ready, which pops the FIFO and increments pix_written.
  - fb_addr/fb_data are held stable while fb_we=1 && fb_ready=0.
  - Write order equals accept order.
- Simultaneous push and pop: count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Counters saturate at all-ones. clear_stats zeroes both; if clear_stats coincides with an increment, the clear wins.
- FSM:
  - IDLE (busy=0): pix_valid or line_done -> ACTIVE. If line_done is present, go -> DRAIN directly; this also covers an all-clipped line arriving with line_done.
  - ACTIVE (busy=1): line_done -> DRAIN. Pixels keep being accepted.
  - DRAIN (busy=1): pixels are still accepted. When the FIFO is empty and there is no push this cycle -> flush_done=1 for exactly one cycle and -> IDLE. busy drops in that same cycle.
  - line_done and pix_valid in the same cycle: the pixel is accepted/pushed and the FSM moves to DRAIN.
  - A line_done in DRAIN is ignored.
- Reset mid-operation: FIFO contents are discarded and no flush_done is issued.

Test Plan:
1. Reset: stream active with 3 pixels buffered, drive rst_in=0 -> immediately fb_we=0, busy=0, oe=1, counters 0. After release no write is issued.
2. Single pixel: (x=3, y=2, color=0x5A) accepted at cycle N, fb_ready=1 -> fb_we=1 at N+1 with fb_addr=643 and fb_data=0x5A. pix_written=1.
3. Backpressure: fb_ready=0, drawer offers 6 pixels, FIFO_DEPTH=4 -> oe=0 after the 4th accept. Set fb_ready=1 -> all 6 written in order, addresses match, pix_written=6.
4. Clipping: pixels (-1,0), (320,5), (0,180), (319,179) -> one write at fb_addr=57599. pix_clipped=3, oe stays 1 throughout.
5. Drain: line_done with 2 pixels buffered and fb_ready=0 -> busy=1, no flush_done. Release fb_ready -> flush_done pulses in the cycle after the last pop, then busy=0.
6. Empty line: line_done alone in IDLE -> flush_done one cycle later. Also check a line_done coinciding with the last pixel -> that pixel is written before flush_done.
